// File: rtl/alu_sequencer.sv
// alu_sequencer: program sequencer that feeds an 8-bit ALU.
// Fetches bytes, loads operands, issues ALU ops and resolves flag branches.
module alu_sequencer #(
    parameter int         ADDR_W    = 8,
    parameter int         ALU_WAIT  = 2,
    parameter logic [7:0] IDLE_INST = 8'hF0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRead,
    input  logic [7:0]        memData,
    output logic [7:0]        operandA,
    output logic [7:0]        operandB,
    output logic [7:0]        ramInst,
    input  logic [7:0]        aluResult,
    input  logic              carryFlag,
    input  logic              compFlag,
    output logic [7:0]        resultOut,
    output logic              resultValid,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc
);

    localparam int CW = $clog2(ALU_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPFETCH,
        S_OPLATCH, S_ISSUE, S_WAIT, S_HALT
    } state_t;

    state_t            state, state_n;
    logic [7:0]        ir, ir_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] pc_n, pc_inc, target, addr_n;
    logic [7:0]        opa_n, opb_n, res_n, inst_n;
    logic              ill_n, rv_n, rd_n, done_n;
    logic              is_alu, is_opnd, is_str, is_nop, is_halt, is_bad;
    logic              take;

    assign pc_inc = pc + ADDR_W'(1);
    assign target = ADDR_W'(memData);
    assign busy   = !(state == S_IDLE || state == S_HALT);

    // decode of the byte arriving on memData (meaningful in DECODE)
    always_comb begin
        is_alu  = 1'b0;
        is_opnd = 1'b0;
        is_str  = 1'b0;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        unique case (1'b1)
            memData[7:4] == 4'h0: is_alu = 1'b1;
            memData inside {8'h10, 8'h11, 8'h20, 8'h21, 8'h22}:
                is_opnd = 1'b1;
            memData == 8'h30: is_str  = 1'b1;
            memData == 8'hFE: is_nop  = 1'b1;
            memData == 8'hFF: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign is_bad = !(is_alu | is_opnd | is_str | is_nop | is_halt);

    always_comb begin
        case (ir)
            8'h20:   take = 1'b1;
            8'h21:   take = carryFlag;
            8'h22:   take = compFlag;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_HALT:
                if (start) state_n = S_FETCH;
            S_FETCH:   state_n = S_DECODE;
            S_DECODE: begin
                if (is_alu)       state_n = S_ISSUE;
                else if (is_opnd) state_n = S_OPFETCH;
                else if (is_halt) state_n = S_HALT;
                else              state_n = S_FETCH;
            end
            S_OPFETCH: state_n = S_OPLATCH;
            S_OPLATCH: state_n = S_FETCH;
            S_ISSUE:   state_n = S_WAIT;
            S_WAIT:
                if (cnt <= CW'(1)) state_n = S_FETCH;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pc_n  = pc;
        ir_n  = ir;
        cnt_n = cnt;
        opa_n = operandA;
        opb_n = operandB;
        res_n = resultOut;
        ill_n = illegal;
        rv_n  = 1'b0;
        unique case (state)
            S_IDLE, S_HALT:
                if (start) begin
                    pc_n  = '0;
                    ill_n = 1'b0;
                end
            S_DECODE: begin
                ir_n = memData;
                pc_n = pc_inc;
                if (is_str) begin
                    res_n = aluResult;
                    rv_n  = 1'b1;
                end
                if (is_bad) ill_n = 1'b1;
            end
            S_OPLATCH: begin
                pc_n = take ? target : pc_inc;
                if (ir == 8'h10) opa_n = memData;
                if (ir == 8'h11) opb_n = memData;
            end
            S_ISSUE: cnt_n = CW'(ALU_WAIT);
            S_WAIT:  cnt_n = cnt - CW'(1);
            default: ;
        endcase
        // strobes are registered, so they follow the state being entered
        rd_n   = (state_n == S_FETCH) || (state_n == S_OPFETCH);
        addr_n = rd_n ? pc_n : '0;
        inst_n = (state == S_DECODE && is_alu) ? memData : IDLE_INST;
        done_n = (state_n == S_HALT) && (state != S_HALT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc          <= '0;
            memAddr     <= '0;
            memRead     <= 1'b0;
            operandA    <= 8'h00;
            operandB    <= 8'h00;
            resultOut   <= 8'h00;
            resultValid <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            ramInst     <= IDLE_INST;
            ir          <= 8'h00;
            cnt         <= '0;
        end else begin
            pc          <= pc_n;
            memAddr     <= addr_n;
            memRead     <= rd_n;
            operandA    <= opa_n;
            operandB    <= opb_n;
            resultOut   <= res_n;
            resultValid <= rv_n;
            done        <= done_n;
            illegal     <= ill_n;
            ramInst     <= inst_n;
            ir          <= ir_n;
            cnt         <= cnt_n;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: instruction-level reference model
// feeds expected fetch/issue/store/done events to a negedge monitor.
module tb_alu_sequencer;

    localparam int         ADDR_W   = 8;
    localparam int         ALU_WAIT = 2;
    localparam logic [7:0] IDLE     = 8'hF0;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic [7:0] memAddr, memData, operandA, operandB, ramInst;
    logic [7:0] aluResult, resultOut, pc;
    logic       memRead, carryFlag, compFlag, resultValid;
    logic       busy, done, illegal;

    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;
    int         edges = 0;
    int         done_cnt = 0;
    int         cf_mode = 0;
    bit         mon_en = 1'b0;
    logic       alu_c, alu_z;
    logic [7:0] alu_r;

    typedef struct {
        logic [7:0] pc;
        logic       ill;
        logic [7:0] a;
        logic [7:0] b;
        int         at_edge;
    } done_t;

    int         fetch_q[$];
    logic [7:0] issue_q[$];
    logic [7:0] store_q[$];
    done_t      done_q[$];
    int         pf[$];
    logic [7:0] pi[$];
    logic [7:0] ps[$];

    logic [7:0] m_a = 0, m_b = 0, m_r = 0;
    logic       m_c = 0, m_z = 0;
    logic [7:0] nx_a, nx_b, nx_r;
    logic       nx_c, nx_z;

    alu_sequencer #(.ADDR_W(ADDR_W), .ALU_WAIT(ALU_WAIT), .IDLE_INST(IDLE)) dut (
        .clk(clk), .resetN(resetN), .start(start),
        .memAddr(memAddr), .memRead(memRead), .memData(memData),
        .operandA(operandA), .operandB(operandB), .ramInst(ramInst),
        .aluResult(aluResult), .carryFlag(carryFlag), .compFlag(compFlag),
        .resultOut(resultOut), .resultValid(resultValid), .busy(busy),
        .done(done), .illegal(illegal), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    function automatic logic [9:0] alu_f(input logic [7:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [8:0] s;
        case (op[3:0])
            4'h3:    s = {1'b0, a} + {1'b0, b};
            4'h4:    s = {1'b0, a} - {1'b0, b};
            default: s = {1'b0, a ^ b};
        endcase
        return {s[8], a < b, s[7:0]};
    endfunction

    always @(posedge clk)
        if (memRead) memData <= mem[memAddr];

    always @(posedge clk or negedge resetN)
        if (!resetN) {alu_c, alu_z, alu_r} <= 10'h0;
        else if (ramInst[7:4] == 4'h0)
            {alu_c, alu_z, alu_r} <= alu_f(ramInst, operandA, operandB);

    assign aluResult = alu_r;
    assign compFlag  = alu_z;
    assign carryFlag = (cf_mode == 1) ? 1'b1 : (cf_mode == 2) ? 1'b0 : alu_c;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic flush();
        fetch_q.delete();
        issue_q.delete();
        store_q.delete();
        done_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && resetN) begin
            if (memRead) begin
                if (fetch_q.size() == 0) bad("fetch_extra", memAddr);
                else chk("fetch_addr", memAddr, fetch_q.pop_front());
            end else begin
                chk("addr_idle", memAddr, 0);
            end
            if (ramInst !== IDLE) begin
                if (issue_q.size() == 0) bad("issue_extra", ramInst);
                else chk("issue_op", ramInst, issue_q.pop_front());
            end
            if (resultValid) begin
                if (store_q.size() == 0) bad("store_extra", resultOut);
                else chk("store_val", resultOut, store_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    bad("done_extra", pc);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_pc", pc, d.pc);
                    chk("done_illegal", illegal, d.ill);
                    chk("done_opA", operandA, d.a);
                    chk("done_opB", operandB, d.b);
                    chk("done_cycle", edges, d.at_edge);
                    chk("done_busy", busy, 0);
                end
                done_cnt++;
            end
        end
    end

    // executes the program in mem at instruction granularity
    task automatic model(output bit ok, output int cyc, output done_t d);
        logic [7:0] p, op, arg, a, b, r;
        logic       c, z, ill, fc;
        a = m_a; b = m_b; r = m_r; c = m_c; z = m_z;
        ill = 0; p = 0; cyc = 0; ok = 0;
        pf.delete(); pi.delete(); ps.delete();
        for (int n = 0; n < 150 && !ok; n++) begin
            pf.push_back(int'(p));
            op = mem[p];
            p++;
            if (op[7:4] == 4'h0) begin
                pi.push_back(op);
                {c, z, r} = alu_f(op, a, b);
                cyc += 3 + ALU_WAIT;
            end else if (op inside {8'h10, 8'h11, 8'h20, 8'h21, 8'h22}) begin
                pf.push_back(int'(p));
                arg = mem[p];
                p++;
                cyc += 4;
                fc = (cf_mode == 1) ? 1'b1 : (cf_mode == 2) ? 1'b0 : c;
                case (op)
                    8'h10: a = arg;
                    8'h11: b = arg;
                    8'h20: p = arg;
                    8'h21: if (fc) p = arg;
                    default: if (z) p = arg;
                endcase
            end else if (op == 8'hFF) begin
                cyc += 2;
                ok = 1;
            end else begin
                cyc += 2;
                if (op == 8'h30) ps.push_back(r);
                else if (op != 8'hFE) ill = 1;
            end
        end
        d.pc = p; d.ill = ill; d.a = a; d.b = b; d.at_edge = 0;
        nx_a = a; nx_b = b; nx_r = r; nx_c = c; nx_z = z;
    endtask

    task automatic run(input bit poke);
        bit    ok, got;
        int    cyc, d0;
        done_t d;
        model(ok, cyc, d);
        if (!ok) begin
            bad("model_nohalt", 0);
            return;
        end
        foreach (pf[i]) fetch_q.push_back(pf[i]);
        foreach (pi[i]) issue_q.push_back(pi[i]);
        foreach (ps[i]) store_q.push_back(ps[i]);
        m_a = nx_a; m_b = nx_b; m_r = nx_r; m_c = nx_c; m_z = nx_z;
        @(negedge clk);
        start = 1'b1;
        d.at_edge = edges + 1 + cyc;
        done_q.push_back(d);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_pc", pc, 0);
        chk("start_illegal", illegal, 0);
        got = 0;
        for (int k = 0; k < cyc + 20 && !got; k++) begin
            @(negedge clk);
            start = (poke && busy && ($urandom_range(0, 2) == 0));
            #1;
            if (done_cnt != d0) got = 1;
        end
        start = 1'b0;
        if (!got) begin
            bad("done_timeout", pc);
            flush();
        end
        chk("queues_drained", fetch_q.size() + issue_q.size() + store_q.size(), 0);
    endtask

    task automatic load(input logic [7:0] p[$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        foreach (p[i]) mem[i] = p[i];
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] prog[$];
        bit         ok, found;
        int         cyc;
        done_t      dd;

        load('{8'hFF});
        repeat (2) @(negedge clk);
        chk("rst_ramInst", ramInst, IDLE);
        chk("rst_regs", {pc, memAddr, operandA, operandB, resultOut}, 0);
        chk("rst_bits", {memRead, resultValid, done, busy, illegal}, 0);
        resetN = 1'b1;
        mon_en = 1'b1;

        prog = '{8'h10, 8'h3C, 8'h11, 8'h0A, 8'h03, 8'h30, 8'hFF};
        load(prog);
        run(0);
        chk("add_result", resultOut, 8'h46);
        chk("add_pc", pc, 7);

        prog = '{8'h21, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF};
        load(prog);
        cf_mode = 1;
        run(1);
        chk("jc_taken_pc", pc, 7);
        cf_mode = 2;
        run(1);
        chk("jc_nottaken_pc", pc, 3);
        cf_mode = 0;

        prog = '{8'h20, 8'hFF};
        load(prog);
        mem[255] = 8'h10;
        run(1);
        chk("wrap_opA", operandA, 8'h20);
        chk("wrap_pc", pc, 2);

        prog = '{8'h77, 8'hFF};
        load(prog);
        run(0);
        chk("illegal_sticky", illegal, 1);

        prog = '{8'h10, 8'h05, 8'h11, 8'h07, 8'h03, 8'h30, 8'hFF};
        load(prog);
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (ramInst == 8'h03) found = 1;
        end
        if (!found) bad("issue_timeout", ramInst);
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_opA", operandA, 8'h05);
        #2 resetN = 1'b0;
        #1;
        chk("arst_ramInst", ramInst, IDLE);
        chk("arst_regs", {pc, memAddr, operandA, operandB, resultOut}, 0);
        chk("arst_bits", {memRead, resultValid, done, busy, illegal}, 0);
        @(negedge clk);
        resetN = 1'b1;
        m_a = 0; m_b = 0; m_r = 0; m_c = 0; m_z = 0;
        flush();
        mon_en = 1'b1;
        run(1);

        for (int t = 0; t < 25; t++) begin
            ok = 0;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
                for (int i = 0; i < 32; i++) begin
                    case ($urandom_range(0, 9))
                        0, 1: mem[i] = 8'($urandom_range(0, 15));
                        2: mem[i] = 8'h10;
                        3: mem[i] = 8'h11;
                        4: mem[i] = 8'h20 + 8'($urandom_range(0, 2));
                        5: mem[i] = 8'h30;
                        6: mem[i] = 8'hFE;
                        7: mem[i] = 8'($urandom_range(8'h40, 8'hEF));
                        default: mem[i] = 8'($urandom_range(0, 31));
                    endcase
                end
                cf_mode = $urandom_range(0, 2);
                model(ok, cyc, dd);
            end
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer that feeds the 8-bit ALU. It fetches instruction bytes from a synchronous program memory and loads immediate operands onto the ALU's A/B inputs. It dispatches ALU opcodes on the instruction bus, waits out the ALU latency, and resolves branches on the ALU's carry and compare flags. It sits between program memory and the ALU and is the only driver of the ALU's `inputA`, `inputB` and `ramInst` inputs.

## Interface
- `ADDR_W`, 8: program counter and memory address width.
- `ALU_WAIT`, 2: idle cycles after an ALU issue before flags and result are sampled; minimum 1.
- `IDLE_INST`, 8'hF0: value driven on `ramInst` whenever no ALU op is issued. It must decode as no-op in the ALU.
- `clk` input 1: clock, all state on rising edge.
- `resetN` input 1: asynchronous active-low reset.
- `start` input 1: level; sampled in IDLE/HALT, begins execution at address 0.
- `memAddr` output ADDR_W: program memory read address.
- `memRead` output 1: read strobe. `memData` is valid on the following cycle.
- `memData` input 8: program memory read data.
- `operandA` output 8: drives ALU `inputA`.
- `operandB` output 8: drives ALU `inputB`.
- `ramInst` output 8: drives ALU opcode input.
- `aluResult` input 8: ALU result.
- `carryFlag` input 1: ALU carry flag.
- `compFlag` input 1: ALU compare flag.
- `resultOut` output 8: captured ALU result.
- `resultValid` output 1: one-cycle pulse when `resultOut` updates.
- `busy` output 1: high in every state except IDLE and HALT.
- `done` output 1: one-cycle pulse on entry to HALT.
- `illegal` output 1: sticky; set by an undefined opcode, cleared by `start` or reset.
- `pc` output ADDR_W: current program counter.

## Operation
- **Instruction encoding:**
  - `0x00`–`0x0F` (high nibble 0): ALU op, forwarded unchanged on `ramInst`.
  - `0x10` LDA imm.
  - `0x11` LDB imm.
  - `0x20` JMP addr.
  - `0x21` JC addr: taken if `carryFlag`.
  - `0x22` JCMP addr: taken if `compFlag`.
  - `0x30` STR: `resultOut` ← `aluResult`, pulse `resultValid`.
  - `0xFE` NOP.
  - `0xFF` HALT.
  - Any other value: behaves as NOP and sets `illegal`.
- **States:** IDLE, FETCH, DECODE, OPFETCH, OPLATCH, ISSUE, WAIT, HALT.
- **IDLE / HALT:** on `start`=1, clear `pc` and `illegal`, then go to FETCH.
- **FETCH:**
  - Drive `memRead`=1, `memAddr`=`pc`.
  - Go to DECODE.
- **DECODE:**
  - Latch `memData` into the instruction register; `pc` ← `pc`+1.
  - ALU op → ISSUE.
  - LDA/LDB/JMP/JC/JCMP → OPFETCH.
  - STR, NOP, illegal → execute in this cycle, then FETCH.
  - HALT → HALT; `pc` holds the address after the HALT byte.
- **OPFETCH:** `memRead`=1, `memAddr`=`pc` (the operand byte).
- **OPLATCH:**
  - `pc` ← `pc`+1.
  - LDA: `operandA` ← `memData`. LDB: `operandB` ← `memData`.
  - JMP, or JC/JCMP with the flag high: `pc` ← `memData[ADDR_W-1:0]`.
  - Then go to FETCH.
- **ISSUE:**
  - `ramInst` = instruction for exactly this one cycle.
  - Load the wait counter with `ALU_WAIT`, go to WAIT.
- **WAIT:** `ramInst`=`IDLE_INST`; decrement the counter; at 0 go to FETCH.
- **Operands:** `operandA`/`operandB` hold their value until the next LDA/LDB.
- **Flags:** sampled combinationally in OPLATCH. The sequencer never modifies them.
- **PC arithmetic:** modulo 2^`ADDR_W`. Increment past all-ones wraps to 0, including an operand fetch across the wrap.
- **Jump target width:** when `ADDR_W` < 8, upper target bits are dropped. When `ADDR_W` > 8, targets are zero-extended.

## Timing
- **Reset values (async, immediate, including mid-instruction):**
  - State IDLE.
  - `pc`, `memAddr`, `operandA`, `operandB`, `resultOut` = 0.
  - `memRead`, `resultValid`, `done`, `busy`, `illegal` = 0.
  - `ramInst` = `IDLE_INST`.
- **Cycles per instruction:**
  - ALU op: 3+`ALU_WAIT`.
  - LDA/LDB/JMP/JC/JCMP: 4, taken or not.
  - STR/NOP/illegal: 2.
  - HALT: 2, then resident.
- **Start latency:** `start` high at edge N gives the first `memRead` in cycle N+1.
- **Strobes:** `memRead` is high only in FETCH and OPFETCH. `memAddr` is 0 when `memRead` is low.
- **Start while busy:** ignored.
- **HALT:** `done` pulses in the first HALT cycle only. A `start` in that same cycle is honoured on the next edge.
- **Output registration:** all outputs are registered except `busy`, which decodes state.

## Test plan
- **Load, add, store.** Program 10 3C 11 0A 03 30 FF, with 0x03 as the ALU add op, `ALU_WAIT`=2, ALU model adds.
  - `operandA`=0x3C and `operandB`=0x0A after cycles 4 and 8.
  - `ramInst`=0x03 for one cycle.
  - `resultOut`=0x46 with a `resultValid` pulse.
  - `done` at cycle 18; `pc`=7.
- **Carry branch.** Force `carryFlag`=1, program 21 05 FF FF FF FE FF.
  - Fetch sequence is 0, 1, 5, 6, HALT.
  - Repeat with `carryFlag`=0: HALT taken at address 2.
- **PC wrap.** `ADDR_W`=4, memory of all NOPs except 0xFF at address 1.
  - Addresses 0..15 are not all visited: execution halts at 1.
  - Then JMP 0x0F followed by LDA whose operand lies at 0x00: operand fetched from address 0, `pc` ends at 1.
- **Illegal opcode.** Program 0x77 FF.
  - `illegal`=1 after cycle 2 and holds through HALT.
  - A subsequent `start` clears it.
- **Reset mid-WAIT.** Assert `resetN`=0 during WAIT of an ALU op.
  - All outputs take reset values the same cycle, without waiting for a clock edge.
  - After release and `start`, fetch resumes at address 0.
- **Start while busy.** Pulse `start` during OPFETCH: no effect on `pc` or the fetch sequence.
